rv_inst_encoder: RTL

- Streaming RV32I(+M) instruction encoder, the inverse of the instruction decoder.
- Accepts a mnemonic index plus operand fields, validates them, and assembles the 32-bit machine word.
- Buffers each word with a running instruction-memory write address.
- Feeds the IMEM loader and self-test program generators through valid/ready handshakes on both sides.

---
 rtl/rv_inst_encoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: streaming RV32I(+M) assembler with operand range checks and an addressed output FIFO
// Ports: clk, reset_n (sync, active low); in_valid/in_ready + in_op, in_rd, in_rs1, in_rs2, in_imm;
//        out_valid/out_ready + out_word, out_addr, out_err; err_count saturates at 16'hFFFF.
// Macro RV_ENC_RV32M_EN enables ops 39-46 (M extension); without it they encode as errored nops.
module rv_inst_encoder #(
  parameter int DEPTH = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       err_count
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [3:0] {F_ILL, F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_SYS} fmt_t;
  logic              s1_valid;
  logic [5:0]        s1_op;
  logic [4:0]        s1_rd, s1_rs1, s1_rs2;
  logic [31:0]       s1_imm;
  fmt_t              fmt;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic [31:0]       word, enc;
  logic              fit12, fit13, fit21, range_ok, err;
  logic [31:0]       mem_word [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic              mem_err  [DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr, fill, one;
  logic [ADDR_W-1:0] addr;
  logic              full, pop, push, room, acc;
  always_comb begin
    fmt = F_ILL;
    opc = 7'h33;
    f3 = 3'd0;
    f7 = 7'h00;
    case (s1_op)
      6'd0:  fmt = F_R;
      6'd1:  begin fmt = F_R; f7 = 7'h20; end
      6'd2:  begin fmt = F_R; f3 = 3'd1; end
      6'd3:  begin fmt = F_R; f3 = 3'd2; end
      6'd4:  begin fmt = F_R; f3 = 3'd3; end
      6'd5:  begin fmt = F_R; f3 = 3'd4; end
      6'd6:  begin fmt = F_R; f3 = 3'd5; end
      6'd7:  begin fmt = F_R; f3 = 3'd5; f7 = 7'h20; end
      6'd8:  begin fmt = F_R; f3 = 3'd6; end
      6'd9:  begin fmt = F_R; f3 = 3'd7; end
      6'd10: begin fmt = F_I; opc = 7'h13; end
      6'd11: begin fmt = F_I; opc = 7'h13; f3 = 3'd2; end
      6'd12: begin fmt = F_I; opc = 7'h13; f3 = 3'd3; end
      6'd13: begin fmt = F_I; opc = 7'h13; f3 = 3'd4; end
      6'd14: begin fmt = F_I; opc = 7'h13; f3 = 3'd6; end
      6'd15: begin fmt = F_I; opc = 7'h13; f3 = 3'd7; end
      6'd16: begin fmt = F_SH; opc = 7'h13; f3 = 3'd1; end
      6'd17: begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; end
      6'd18: begin fmt = F_SH; opc = 7'h13; f3 = 3'd5; f7 = 7'h20; end
      6'd19: begin fmt = F_I; opc = 7'h03; end
      6'd20: begin fmt = F_I; opc = 7'h03; f3 = 3'd1; end
      6'd21: begin fmt = F_I; opc = 7'h03; f3 = 3'd2; end
      6'd22: begin fmt = F_I; opc = 7'h03; f3 = 3'd4; end
      6'd23: begin fmt = F_I; opc = 7'h03; f3 = 3'd5; end
      6'd24: begin fmt = F_S; opc = 7'h23; end
      6'd25: begin fmt = F_S; opc = 7'h23; f3 = 3'd1; end
      6'd26: begin fmt = F_S; opc = 7'h23; f3 = 3'd2; end
      6'd27: begin fmt = F_B; opc = 7'h63; end
      6'd28: begin fmt = F_B; opc = 7'h63; f3 = 3'd1; end
      6'd29: begin fmt = F_B; opc = 7'h63; f3 = 3'd4; end
      6'd30: begin fmt = F_B; opc = 7'h63; f3 = 3'd5; end
      6'd31: begin fmt = F_B; opc = 7'h63; f3 = 3'd6; end
      6'd32: begin fmt = F_B; opc = 7'h63; f3 = 3'd7; end
      6'd33: begin fmt = F_U; opc = 7'h37; end
      6'd34: begin fmt = F_U; opc = 7'h17; end
      6'd35: begin fmt = F_J; opc = 7'h6F; end
      6'd36: begin fmt = F_I; opc = 7'h67; end
      6'd37, 6'd38: begin fmt = F_SYS; opc = 7'h73; end
`ifdef RV_ENC_RV32M_EN
      // ops 39..46 map onto funct3 0..7: low three op bits plus one, modulo 8
      6'd39, 6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46: begin
        fmt = F_R;
        f7 = 7'h01;
        f3 = s1_op[2:0] + 3'd1;
      end
`endif
      default: fmt = F_ILL;
    endcase
  end
  always_comb begin
    word = 32'h0000_0013;
    case (fmt)
      F_R:     word = {f7, s1_rs2, s1_rs1, f3, s1_rd, opc};
      F_I:     word = {s1_imm[11:0], s1_rs1, f3, s1_rd, opc};
      F_SH:    word = {f7, s1_imm[4:0], s1_rs1, f3, s1_rd, opc};
      F_S:     word = {s1_imm[11:5], s1_rs2, s1_rs1, f3, s1_imm[4:0], opc};
      F_B:     word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, f3, s1_imm[4:1], s1_imm[11], opc};
      F_U:     word = {s1_imm[19:0], s1_rd, opc};
      F_J:     word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, opc};
      F_SYS:   word = {11'd0, s1_op == 6'd38, 13'd0, opc};
      default: word = 32'h0000_0013;
    endcase
  end
  // a signed value fits N bits when everything from bit N-1 upward is a pure sign extension
  assign fit12 = &s1_imm[31:11] | ~|s1_imm[31:11];
  assign fit13 = &s1_imm[31:12] | ~|s1_imm[31:12];
  assign fit21 = &s1_imm[31:20] | ~|s1_imm[31:20];
  assign range_ok = (fmt == F_I || fmt == F_S) ? fit12 :
                    (fmt == F_SH) ? ~|s1_imm[31:5] :
                    (fmt == F_B)  ? fit13 & ~s1_imm[0] :
                    (fmt == F_J)  ? fit21 & ~s1_imm[0] : 1'b1;
  assign err = fmt == F_ILL || !range_ok;
  assign enc = err ? 32'h0000_0013 : word;
  assign one = {{PW{1'b0}}, 1'b1};
  assign fill = wr_ptr - rd_ptr;
  assign full = fill[PW];
  assign out_valid = wr_ptr != rd_ptr;
  assign pop = out_valid && out_ready;
  assign room = !full || pop;
  assign push = s1_valid && room;
  assign in_ready = !s1_valid || room;
  assign acc = in_valid && in_ready;
  assign out_word = out_valid ? mem_word[rd_ptr[PW-1:0]] : 32'd0;
  assign out_addr = out_valid ? mem_addr[rd_ptr[PW-1:0]] : '0;
  assign out_err = out_valid && mem_err[rd_ptr[PW-1:0]];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      addr <= ADDR_W'(BASE_ADDR);
      err_count <= 16'd0;
    end else begin
      s1_valid <= acc || (s1_valid && !push);
      if (push) wr_ptr <= wr_ptr + one;
      if (push) addr <= addr + ADDR_W'(4);
      if (push && err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (pop) rd_ptr <= rd_ptr + one;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      s1_op <= in_op;
      s1_rd <= in_rd;
      s1_rs1 <= in_rs1;
      s1_rs2 <= in_rs2;
      s1_imm <= in_imm;
    end
    if (push) begin
      mem_word[wr_ptr[PW-1:0]] <= enc;
      mem_addr[wr_ptr[PW-1:0]] <= addr;
      mem_err[wr_ptr[PW-1:0]] <= err;
    end
  end
endmodule
